// File: rtl/lockin_pkg.sv
// lockin_pkg: shared widths, FSM encoding and saturation range helper for the lock-in integrator
package lockin_pkg;
  localparam int ACC_W_DEF = 96;
  localparam int OUT_W_DEF = 64;
  localparam int IN_W = 64;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;
  function automatic logic [1:0] sat_dir(input logic signed [127:0] v, input int w);
    logic signed [127:0] hi;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    return {v > hi, v < -hi - 128'sd1};
  endfunction
endpackage

// File: rtl/lockin_integrator_if.sv
// lockin_integrator_if: product input stream and X/Y Avalon-ST result stream
interface lockin_integrator_if import lockin_pkg::*; #(
  parameter int OUT_W = OUT_W_DEF
);
  logic signed [IN_W-1:0] data_in_seno;
  logic signed [IN_W-1:0] data_in_coseno;
  logic data_valid_in;
  logic signed [OUT_W-1:0] data_out_x;
  logic signed [OUT_W-1:0] data_out_y;
  logic data_valid_out;
  logic data_ready_out;
  modport master(
    input data_in_seno, data_in_coseno, data_valid_in, data_ready_out,
    output data_out_x, data_out_y, data_valid_out
  );
  modport slave(
    output data_in_seno, data_in_coseno, data_valid_in, data_ready_out,
    input data_out_x, data_out_y, data_valid_out
  );
endinterface

// File: rtl/lockin_acc_channel.sv
// lockin_acc_channel: one-channel accumulator, frame hold register and shift/saturate output stage
module lockin_acc_channel import lockin_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic take,
  input  logic last,
  input  logic load,
  input  logic [6:0] shift,
  input  logic signed [IN_W-1:0] din,
  output logic signed [OUT_W-1:0] dout
);
  logic signed [ACC_W-1:0] acc, hold, base, sum, shd;
  logic [1:0] dir;
  always_comb begin
    base = clr ? '0 : acc;
    sum = base + {{(ACC_W-IN_W){din[IN_W-1]}}, din};
    shd = hold >>> shift;
    dir = sat_dir({{(128-ACC_W){shd[ACC_W-1]}}, shd}, OUT_W);
  end
  always_ff @(posedge clock)
    if (reset) begin
      acc <= '0;
      hold <= '0;
      dout <= '0;
    end else begin
      acc <= last ? '0 : take ? sum : base;
      hold <= last ? sum : hold;
      dout <= !load ? dout : dir[1] ? {1'b0, {(OUT_W-1){1'b1}}} : dir[0] ? {1'b1, {(OUT_W-1){1'b0}}} : shd[OUT_W-1:0];
    end
endmodule

// File: rtl/lockin_integrator.sv
// lockin_integrator: sums sine/cosine products over N cycles of M points and emits scaled X/Y
module lockin_integrator import lockin_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic start,
  input  logic continuous,
  input  logic [15:0] ptos_x_ciclo,
  input  logic [15:0] n_ciclos,
  input  logic [6:0] shift,
  lockin_integrator_if.master st,
  output logic busy,
  output logic overrun
);
  logic [0:0] state;
  logic [15:0] m_r, n_r, m_in, n_in, m_eff, n_eff, s_cnt, c_cnt, sample_cnt, cycle_cnt;
  logic [6:0] shift_r, shift_eff, hold_shift;
  logic take, wrap, last, rearm, hold_vld;
  always_comb begin
    m_in = ptos_x_ciclo == '0 ? 16'd1 : ptos_x_ciclo;
    n_in = n_ciclos == '0 ? 16'd1 : n_ciclos;
    m_eff = start ? m_in : m_r;
    n_eff = start ? n_in : n_r;
    shift_eff = start ? shift : shift_r;
    s_cnt = start ? '0 : sample_cnt;
    c_cnt = start ? '0 : cycle_cnt;
    take = enable && st.data_valid_in && (start || state == ST_ACCUM);
    wrap = s_cnt == m_eff - 16'd1;
    last = take && wrap && c_cnt == n_eff - 16'd1;
    rearm = start || (last && continuous);
  end
  assign busy = state == ST_ACCUM;
  always_ff @(posedge clock)
    if (reset) begin
      state <= ST_IDLE;
      m_r <= 16'd1;
      n_r <= 16'd1;
      shift_r <= '0;
      sample_cnt <= '0;
      cycle_cnt <= '0;
      hold_vld <= 1'b0;
      hold_shift <= '0;
      st.data_valid_out <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= last ? (continuous ? ST_ACCUM : ST_IDLE) : start ? ST_ACCUM : state;
      m_r <= rearm ? m_in : m_r;
      n_r <= rearm ? n_in : n_r;
      shift_r <= rearm ? shift : shift_r;
      sample_cnt <= take ? (wrap ? '0 : s_cnt + 16'd1) : s_cnt;
      cycle_cnt <= last ? '0 : (take && wrap) ? c_cnt + 16'd1 : c_cnt;
      hold_vld <= last;
      hold_shift <= last ? shift_eff : hold_shift;
      st.data_valid_out <= hold_vld || (st.data_valid_out && !st.data_ready_out);
      overrun <= (hold_vld && st.data_valid_out && !st.data_ready_out) || (overrun && !start);
    end
  lockin_acc_channel #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_x (
    .clock(clock), .reset(reset), .clr(start), .take(take), .last(last), .load(hold_vld),
    .shift(hold_shift), .din(st.data_in_seno), .dout(st.data_out_x)
  );
  lockin_acc_channel #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_y (
    .clock(clock), .reset(reset), .clr(start), .take(take), .last(last), .load(hold_vld),
    .shift(hold_shift), .din(st.data_in_coseno), .dout(st.data_out_y)
  );
endmodule

// File: tb/tb_lockin_integrator.sv
// tb_lockin_integrator: directed stimulus with a result scoreboard drained by an output monitor
module tb_lockin_integrator;
  typedef struct { longint x; longint y; } exp_t;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b1, start = 1'b0, continuous = 1'b0;
  logic [15:0] ptos_x_ciclo = 16'd1, n_ciclos = 16'd1;
  logic [6:0] shift = '0;
  logic busy, overrun;
  int checks = 0, failures = 0;
  exp_t exp_q[$];
  localparam longint MAXV = longint'(64'h7FFF_FFFF_FFFF_FFFF);
  localparam longint MINV = longint'(64'h8000_0000_0000_0000);
  lockin_integrator_if #(.OUT_W(64)) st();
  lockin_integrator dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .continuous(continuous),
    .ptos_x_ciclo(ptos_x_ciclo), .n_ciclos(n_ciclos), .shift(shift), .st(st.master),
    .busy(busy), .overrun(overrun)
  );
  always #5 clock = ~clock;
  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic start_frame(int m, int n, int sh);
    ptos_x_ciclo = 16'(m);
    n_ciclos = 16'(n);
    shift = 7'(sh);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic smp(longint s, longint c, logic en);
    st.data_in_seno = s;
    st.data_in_coseno = c;
    st.data_valid_in = 1'b1;
    enable = en;
    tick(1);
    st.data_valid_in = 1'b0;
    enable = 1'b1;
  endtask
  task automatic push(longint x, longint y);
    exp_t e;
    e.x = x;
    e.y = y;
    exp_q.push_back(e);
  endtask
  task automatic drain(string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clock);
      n++;
    end
    chk(nm, longint'(exp_q.size()), 0);
    @(posedge clock);
    #1;
  endtask
  always @(negedge clock)
    if (!reset && st.data_valid_out && st.data_ready_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got x=%0d y=%0d expected no result", st.data_out_x, st.data_out_y);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_x", st.data_out_x, e.x);
        chk("res_y", st.data_out_y, e.y);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    st.data_in_seno = '0;
    st.data_in_coseno = '0;
    st.data_valid_in = 1'b0;
    st.data_ready_out = 1'b1;
    tick(3);
    @(negedge clock);
    chk("rst_valid", st.data_valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_x", st.data_out_x, 0);
    chk("rst_y", st.data_out_y, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    tick(1);
    start_frame(4, 2, 0);
    chk("busy_accum", busy, 1);
    push(80, -24);
    for (int i = 0; i < 8; i++) smp(10, -3, 1'b1);
    @(negedge clock);
    chk("lat_e0_valid", st.data_valid_out, 0);
    chk("busy_after_frame", busy, 0);
    @(negedge clock);
    chk("lat_e1_valid", st.data_valid_out, 1);
    drain("drain_t1");
    start_frame(4, 1, 0);
    push(MAXV, MINV);
    for (int i = 0; i < 4; i++) smp(longint'(64'h4000_0000_0000_0000), longint'(64'hC000_0000_0000_0000), 1'b1);
    drain("drain_t2");
    start_frame(2, 1, 3);
    push(125, -126);
    smp(500, -500, 1'b1);
    smp(500, -501, 1'b1);
    drain("drain_t3");
    st.data_ready_out = 1'b0;
    continuous = 1'b1;
    start_frame(2, 1, 0);
    smp(1, 2, 1'b1);
    tick(1);
    smp(3, 4, 1'b1);
    tick(2);
    smp(5, 6, 1'b1);
    tick(1);
    smp(7, 8, 1'b1);
    @(negedge clock);
    @(negedge clock);
    chk("ovr_valid", st.data_valid_out, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_x", st.data_out_x, 12);
    chk("ovr_y", st.data_out_y, 14);
    push(12, 14);
    @(posedge clock);
    #1 st.data_ready_out = 1'b1;
    continuous = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("valid_drop", st.data_valid_out, 0);
    drain("drain_t4");
    start_frame(8, 1, 0);
    chk("start_clr_overrun", overrun, 0);
    for (int i = 0; i < 11; i++) smp(1, 1, !(i == 2 || i == 5 || i == 9));
    push(8, 8);
    drain("drain_t5");
    start_frame(8, 1, 0);
    for (int i = 0; i < 5; i++) smp(100, 100, 1'b1);
    push(4, 8);
    ptos_x_ciclo = 16'd4;
    n_ciclos = 16'd1;
    st.data_in_seno = 1;
    st.data_in_coseno = 2;
    st.data_valid_in = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    st.data_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) smp(1, 2, 1'b1);
    drain("drain_t6");
    start_frame(4, 1, 0);
    smp(7, 7, 1'b1);
    smp(7, 7, 1'b1);
    reset = 1'b1;
    tick(2);
    @(negedge clock);
    chk("mid_rst_valid", st.data_valid_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_x", st.data_out_x, 0);
    chk("mid_rst_y", st.data_out_y, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    smp(7, 7, 1'b1);
    smp(7, 7, 1'b1);
    tick(6);
    chk("idle_after_rst", busy, 0);
    chk("idle_no_valid", st.data_valid_out, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
